call_registry: RTL and testbench
================================

# call_registry

Clocked, parametrised request register for the elevator controller. It captures cabin and hall calls from raw push-buttons through a synchroniser, a debouncer and an edge detector, then holds each call until the motion controller reports the floor serviced. It also derives above/below/here summaries relative to the current floor for the direction-selection FSM. It sits between the button pads and the motion controller, and supersedes the combinational set/clear latch bank.

## Interface
Parameters:
- FLOORS, 8, number of served floors (≥2)
- FLOOR_W, $clog2(FLOORS), width of floor indices
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a level change (≥1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- btn_in  in  FLOORS  raw cabin buttons, asynchronous
- btn_up  in  FLOORS  raw hall-up buttons; bit FLOORS-1 ignored
- btn_down  in  FLOORS  raw hall-down buttons; bit 0 ignored
- service_valid  in  1  one-cycle strobe: car stopped and doors opened at service_floor
- service_floor  in  FLOOR_W  floor being serviced
- service_dir  in  1  departure direction (DIR_UP=0, DIR_DOWN=1)
- cur_floor  in  FLOOR_W  current car floor
- active_in  out  FLOORS  latched cabin calls
- active_up  out  FLOORS  latched hall-up calls
- active_down  out  FLOORS  latched hall-down calls
- any_request  out  1  OR of all active bits
- req_above  out  1  any active call at a floor > cur_floor
- req_below  out  1  any active call at a floor < cur_floor
- req_here  out  1  any active call at cur_floor

## Operation
- Each of the 3×FLOORS buttons has its own chain: 2-flop synchroniser, debounce FSM, rising-edge detector.
- Debounce FSM states:
  - LOW: synchronised sample high → ARM_HI with cnt=1.
  - ARM_HI: sample high → cnt++; when cnt reaches DEBOUNCE_CYCLES → HIGH, deb=1. Sample low → LOW, cnt=0.
  - HIGH: sample low → ARM_LO with cnt=1.
  - ARM_LO: symmetric to ARM_HI; reaching DEBOUNCE_CYCLES → LOW, deb=0. Sample high → HIGH.
- Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Set: a 0→1 edge of deb sets the corresponding active bit. A button held down after being cleared does not re-set its call; it must be released (debounced low) and pressed again.
- Clear, on service_valid with service_floor < FLOORS:
  - Always clear active_in[service_floor].
  - Clear active_up[service_floor] if service_dir=DIR_UP, else clear active_down[service_floor].
  - service_floor ≥ FLOORS: strobe ignored.
- Set and clear of the same bit in the same cycle: set wins, and the bit stays 1.
- Masked bits: active_up[FLOORS-1] and active_down[0] are constant 0 regardless of inputs.
- Summaries are combinational from the active registers and cur_floor.
  - cur_floor ≥ FLOORS: req_here=0, req_above=0, req_below=any_request.
  - cur_floor=0 forces req_below=0; cur_floor=FLOORS-1 forces req_above=0.
- Reset mid-press:
  - All state returns to LOW/cnt=0/active=0.
  - A button still held when reset falls is treated as a new press, so the call is accepted after the full latency.

## Timing
- Reset values: all active_* = 0; any_request, req_above, req_below, req_here = 0; every debouncer in LOW with cnt=0 and deb=0.
- Press latency: raw input first high at edge 0 and held stable → active bit is 1 after edge DEBOUNCE_CYCLES+2. It is visible in the following cycle, i.e. L = DEBOUNCE_CYCLES+3 cycles.
- Glitches: a synchronised pulse shorter than DEBOUNCE_CYCLES samples never sets a call.
- Clear latency: the active bit is 0 in the cycle after the edge that samples service_valid=1.
- Summary outputs follow register changes with zero additional latency.
- No handshake back to the motion controller; service_valid is fire-and-forget.

## Structure
- Shared package elevator_pkg holds:
  - the DIR_UP/DIR_DOWN constants;
  - a floor-index width helper;
  - the debounce state encoding (LOW, ARM_HI, HIGH, ARM_LO).
- Sub-module button_debounce: one bit, with synchroniser, debounce FSM and rising-edge pulse output. Parameter DEBOUNCE_CYCLES; generated 3×FLOORS times.
- The top level contains only the set/clear registers and the summary logic.

## Test plan
All scenarios use FLOORS=8 and DEBOUNCE_CYCLES=4.
- Clean press: btn_in[5] held high 20 cycles → active_in[5]=1 exactly 7 cycles after the first high sample; any_request=1. With cur_floor=2: req_above=1, req_below=0.
- Bounce rejection: btn_up[3] toggled with 3-cycle high pulses separated by 1-cycle lows → active_up stays 0. Then held high 10 cycles → active_up[3]=1.
- Directional clear: active_up[4]=1, active_down[4]=1, active_in[4]=1; service_valid with service_floor=4 and service_dir=DIR_DOWN → next cycle active_in[4]=0, active_down[4]=0, active_up[4]=1.
- Held button after clear: btn_in[2] kept high across a service of floor 2 → active_in[2] stays 0. Release ≥4 cycles, press again → active_in[2]=1 after 7 cycles.
- Set/clear collision: debounced edge of btn_in[6] lands in the same cycle as service of floor 6 → active_in[6]=1. Masked inputs btn_up[7] and btn_down[0] held high → their active bits stay 0.
- Async reset mid-count: reset pulsed while btn_in[1] is 3 samples into ARM_HI, button kept held → all outputs 0 during reset; active_in[1]=1 exactly 7 cycles after reset deasserts.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared elevator definitions: travel direction codes, floor-index width helper
// and the button debounce state encoding.
package elevator_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef logic [1:0] deb_state_t;

  localparam deb_state_t DEB_LOW    = 2'd0;
  localparam deb_state_t DEB_ARM_HI = 2'd1;
  localparam deb_state_t DEB_HIGH   = 2'd2;
  localparam deb_state_t DEB_ARM_LO = 2'd3;

  // Never returns 0 so a two-floor building still gets a 1-bit index.
  function automatic int floor_w(input int floors);
    return (floors <= 2) ? 1 : $clog2(floors);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button: 2-flop synchroniser, debounce FSM and a one-cycle pulse on
// each accepted press. The FSM state is exported for observation.
module button_debounce
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw,
  output logic       rise,
  output deb_state_t state
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             deb;
  logic             deb_q;
  logic [CNT_W-1:0] cnt;

  // cnt holds the number of agreeing samples seen so far, so the sample that
  // finds cnt == CNT_LAST is the one completing the required run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb_q <= 1'b0;
      state <= DEB_LOW;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      case (state)
        DEB_LOW, DEB_ARM_HI: begin
          if (!sync2) begin
            state <= DEB_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= DEB_HIGH;
            cnt   <= '0;
          end else begin
            state <= DEB_ARM_HI;
            cnt   <= cnt + CNT_W'(1);
          end
        end
        default: begin
          if (sync2) begin
            state <= DEB_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= DEB_LOW;
            cnt   <= '0;
          end else begin
            state <= DEB_ARM_LO;
            cnt   <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign deb  = (state == DEB_HIGH) || (state == DEB_ARM_LO);
  assign rise = deb && !deb_q;

endmodule

// File: rtl/call_registry.sv
// Elevator call register: debounced button presses latch calls until the
// motion controller reports the floor serviced; summaries relative to cur_floor.
module call_registry
  import elevator_pkg::*;
#(
  parameter int FLOORS          = 8,
  parameter int FLOOR_W         = floor_w(FLOORS),
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  btn_in,
  input  logic [FLOORS-1:0]  btn_up,
  input  logic [FLOORS-1:0]  btn_down,
  input  logic               service_valid,
  input  logic [FLOOR_W-1:0] service_floor,
  input  logic               service_dir,
  input  logic [FLOOR_W-1:0] cur_floor,
  output logic [FLOORS-1:0]  active_in,
  output logic [FLOORS-1:0]  active_up,
  output logic [FLOORS-1:0]  active_down,
  output logic               any_request,
  output logic               req_above,
  output logic               req_below,
  output logic               req_here
);

  // No hall-up call at the top floor, no hall-down call at the bottom floor.
  localparam logic [FLOORS-1:0] UP_MASK   = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DOWN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

  logic       [FLOORS-1:0] rise_in, rise_up, rise_down;
  deb_state_t [FLOORS-1:0] st_in, st_up, st_down;
  logic                    unused_dbg;

  for (genvar f = 0; f < FLOORS; f++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_in (
      .clk(clk), .reset(reset), .raw(btn_in[f]), .rise(rise_in[f]), .state(st_in[f])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clk(clk), .reset(reset), .raw(btn_up[f]), .rise(rise_up[f]), .state(st_up[f])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
      .clk(clk), .reset(reset), .raw(btn_down[f]), .rise(rise_down[f]), .state(st_down[f])
    );
  end

  assign unused_dbg = ^{st_in, st_up, st_down};

  // service_valid is a single-cycle strobe with no ready: it takes effect on
  // the edge that samples it, and a strobe naming a nonexistent floor is dropped.
  logic              svc_hit;
  logic [FLOORS-1:0] svc_onehot, clr_up, clr_down;

  assign svc_hit    = service_valid && (int'(service_floor) < FLOORS);
  assign svc_onehot = svc_hit ? (FLOORS'(1) << service_floor) : '0;
  assign clr_up     = (service_dir == DIR_UP) ? svc_onehot : '0;
  assign clr_down   = (service_dir == DIR_UP) ? '0 : svc_onehot;

  // A fresh press wins over a simultaneous clear of the same call.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_in   <= '0;
      active_up   <= '0;
      active_down <= '0;
    end else begin
      active_in   <= (active_in & ~svc_onehot) | rise_in;
      active_up   <= ((active_up & ~clr_up) | rise_up) & UP_MASK;
      active_down <= ((active_down & ~clr_down) | rise_down) & DOWN_MASK;
    end
  end

  logic [FLOORS-1:0] all_req;
  assign all_req     = active_in | active_up | active_down;
  assign any_request = |all_req;

  always_comb begin
    req_above = 1'b0;
    req_below = 1'b0;
    req_here  = 1'b0;
    if (int'(cur_floor) >= FLOORS) begin
      req_below = any_request;
    end else begin
      for (int i = 0; i < FLOORS; i++) begin
        if (i > int'(cur_floor)) req_above = req_above | all_req[i];
        if (i < int'(cur_floor)) req_below = req_below | all_req[i];
        if (i == int'(cur_floor)) req_here = req_here | all_req[i];
      end
    end
  end

endmodule

// File: tb/tb_call_registry.sv
// Bench for call_registry: directed scenarios with literal expectations plus
// randomized button/service traffic checked every cycle against a call model.
module tb_call_registry;

  localparam int F  = 8;
  localparam int D  = 4;
  localparam int FW = 3;
  localparam int NB = 3 * F;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [F-1:0]  btn_in = '0, btn_up = '0, btn_down = '0;
  logic          service_valid = 1'b0;
  logic [FW-1:0] service_floor = '0;
  logic          service_dir = 1'b0;
  logic [FW-1:0] cur_floor = '0;
  logic [F-1:0]  active_in, active_up, active_down;
  logic          any_request, req_above, req_below, req_here;

  int checks = 0;
  int errors = 0;

  call_registry #(.FLOORS(F), .FLOOR_W(FW), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset),
    .btn_in(btn_in), .btn_up(btn_up), .btn_down(btn_down),
    .service_valid(service_valid), .service_floor(service_floor),
    .service_dir(service_dir), .cur_floor(cur_floor),
    .active_in(active_in), .active_up(active_up), .active_down(active_down),
    .any_request(any_request), .req_above(req_above),
    .req_below(req_below), .req_here(req_here)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Button b: 0..F-1 cabin, F..2F-1 hall-up, 2F..3F-1 hall-down. Each press
  // level flips once the last D synchronised samples all disagree with it.
  bit           p1[NB], p2[NB], deb_m[NB], pend[NB];
  bit           win[NB][$];
  logic [F-1:0] m_in = '0, m_up = '0, m_dn = '0;

  function automatic bit raw_bit(input int b);
    if (b < F) return btn_in[b];
    if (b < 2 * F) return btn_up[b - F];
    return btn_down[b - 2 * F];
  endfunction

  function automatic bit settled(input int b, input bit v);
    if (win[b].size() < D) return 1'b0;
    for (int i = 0; i < win[b].size(); i++)
      if (win[b][i] != v) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NB; b++) begin
        p1[b] = 0; p2[b] = 0; deb_m[b] = 0; pend[b] = 0;
        win[b].delete();
      end
      m_in = '0; m_up = '0; m_dn = '0;
    end else begin
      for (int f = 0; f < F; f++) begin
        bit hit;
        hit = service_valid && (int'(service_floor) == f);
        if (hit) m_in[f] = 1'b0;
        if (hit && service_dir == 1'b0) m_up[f] = 1'b0;
        if (hit && service_dir == 1'b1) m_dn[f] = 1'b0;
        if (pend[f]) m_in[f] = 1'b1;
        if (pend[F + f] && f != F - 1) m_up[f] = 1'b1;
        if (pend[2 * F + f] && f != 0) m_dn[f] = 1'b1;
      end
      for (int b = 0; b < NB; b++) begin
        win[b].push_back(p2[b]);
        if (win[b].size() > D) void'(win[b].pop_front());
        p2[b] = p1[b];
        p1[b] = raw_bit(b);
        pend[b] = 0;
        if (settled(b, !deb_m[b])) begin
          deb_m[b] = !deb_m[b];
          pend[b]  = deb_m[b];
        end
      end
    end
  end

  function automatic logic [3:0] model_sum();
    logic [F-1:0] all;
    logic a, bl, h;
    all = m_in | m_up | m_dn;
    a = 0; bl = 0; h = 0;
    for (int f = 0; f < F; f++) begin
      if (all[f] && f > int'(cur_floor)) a = 1;
      if (all[f] && f < int'(cur_floor)) bl = 1;
      if (all[f] && f == int'(cur_floor)) h = 1;
    end
    return {|all, a, bl, h};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("model_active_in", active_in, m_in);
      chk("model_active_up", active_up, m_up);
      chk("model_active_down", active_down, m_dn);
      chk("model_summary", {any_request, req_above, req_below, req_here}, model_sum());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic service(input int fl, input logic dir);
    service_valid = 1'b1;
    service_floor = FW'(fl);
    service_dir   = dir;
    tick(1);
    service_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick(3);
    chk("reset_active_in", active_in, 0);
    chk("reset_active_up", active_up, 0);
    chk("reset_active_down", active_down, 0);
    chk("reset_summary", {any_request, req_above, req_below, req_here}, 0);
    reset = 1'b0;
    cur_floor = 3'd2;
    tick(2);

    // Clean press: 7-cycle latency.
    btn_in[5] = 1'b1;
    tick(6);
    chk("press_early", active_in[5], 0);
    tick(1);
    chk("press_set", active_in[5], 1);
    chk("press_summary", {any_request, req_above, req_below, req_here}, 4'b1100);
    tick(13);
    btn_in[5] = 1'b0;
    tick(8);
    service(5, 1'b0);
    chk("press_clear", active_in[5], 0);

    // Bounce rejection.
    repeat (4) begin
      btn_up[3] = 1'b1; tick(3);
      btn_up[3] = 1'b0; tick(1);
    end
    tick(6);
    chk("bounce_reject", active_up, 0);
    btn_up[3] = 1'b1;
    tick(10);
    chk("bounce_accept", active_up, 8'h08);
    btn_up[3] = 1'b0;
    tick(8);

    // Directional clear.
    btn_in[4] = 1'b1; btn_up[4] = 1'b1; btn_down[4] = 1'b1;
    tick(8);
    btn_in[4] = 1'b0; btn_up[4] = 1'b0; btn_down[4] = 1'b0;
    tick(8);
    chk("dir_pre", {active_in[4], active_up[4], active_down[4]}, 3'b111);
    service(4, 1'b1);
    chk("dir_clear", {active_in[4], active_up[4], active_down[4]}, 3'b010);

    // Held button across service does not re-latch.
    btn_in[2] = 1'b1;
    tick(8);
    chk("held_set", active_in[2], 1);
    service(2, 1'b0);
    chk("held_clear", active_in[2], 0);
    tick(10);
    chk("held_no_reset", active_in[2], 0);
    btn_in[2] = 1'b0;
    tick(8);
    btn_in[2] = 1'b1;
    tick(6);
    chk("repress_early", active_in[2], 0);
    tick(1);
    chk("repress_set", active_in[2], 1);
    btn_in[2] = 1'b0;

    // Set/clear collision, then masked buttons.
    btn_in[6] = 1'b1;
    tick(6);
    service(6, 1'b0);
    chk("collision_set_wins", active_in[6], 1);
    btn_in[6] = 1'b0;
    btn_up[7] = 1'b1; btn_down[0] = 1'b1;
    tick(10);
    chk("mask_up7", active_up[7], 0);
    chk("mask_down0", active_down[0], 0);
    btn_up[7] = 1'b0; btn_down[0] = 1'b0;
    tick(8);

    // Async reset mid-count with button held.
    btn_in[1] = 1'b1;
    tick(5);
    reset = 1'b1;
    tick(1);
    chk("rst_mid_active", {active_in, active_up, active_down}, 0);
    chk("rst_mid_summary", {any_request, req_above, req_below, req_here}, 0);
    reset = 1'b0;
    tick(6);
    chk("rst_press_early", active_in[1], 0);
    tick(1);
    chk("rst_press_set", active_in[1], 1);
    btn_in[1] = 1'b0;
    tick(8);

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 599) == 0);
      for (int f = 0; f < F; f++) begin
        if ($urandom_range(0, 15) == 0) btn_in[f] = ~btn_in[f];
        if ($urandom_range(0, 15) == 0) btn_up[f] = ~btn_up[f];
        if ($urandom_range(0, 15) == 0) btn_down[f] = ~btn_down[f];
      end
      service_valid = ($urandom_range(0, 3) == 0);
      service_floor = FW'($urandom_range(0, F - 1));
      service_dir   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) cur_floor = FW'($urandom_range(0, F - 1));
    end
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
